// File: rtl/alu_decoder_stage.sv
// ============================================================================
// alu_decoder_stage
// ----------------------------------------------------------------------------
// Registered ALU control decoder between the decode and execute stages.
//
// What it does:
//   - Turns the ALU operation class and the instruction fields into an ALU
//     control code.
//   - Decodes RV32M/RV64M multiply and divide operations.
//   - Flags RV64 word (W-variant) operations.
//   - Holds the decoded result in a single valid/ready pipeline register.
//   - Stalls decode for DIV_CYCLES cycles after a divide-class op (DIV, DIVU,
//     REM, REMU) leaves the register. This models an iterative divider that
//     is still busy.
//
// Parameters:
//   XLEN       : 32 or 64. At 64 the stage flags word ops (op_bit3).
//   CTRL_W     : width of alu_ctrl. Must be >= 5.
//   DIV_CYCLES : stall length after a divide-class op. 0 disables the stall.
//
// Ports:
//   clk        : clock, rising edge
//   resetn     : asynchronous reset, active low
//   flush      : synchronous kill of the register contents and of the stall
//   in_valid   : upstream offers a decoded instruction
//   in_ready   : stage accepts this cycle
//   alu_op     : operation class (0 ADD, 1 SUB, 2 AUIPC, 3 LUI, 4 BRANCH,
//                5 ARITH_LOGIC, 6/7 reserved)
//   funct3     : instr[14:12]
//   funct7     : instr[31:25]
//   imm_bit10  : instr[30], selects SRAI over SRLI in the immediate form
//   op_bit5    : instr[5], 1 = register form, 0 = immediate form
//   op_bit3    : instr[3], 1 = OP-32 / OP-IMM-32
//   out_valid  : register holds a valid result
//   out_ready  : execute accepts the result
//   alu_ctrl   : ALU control code, zero-extended to CTRL_W
//   is_muldiv  : result is an M-extension op
//   word_op    : 32-bit W-variant (always 0 when XLEN=32)
//   illegal    : only present when ALU_DECODER_ILLEGAL_CHECK_EN is defined
//
// Optional feature, macro ALU_DECODER_ILLEGAL_CHECK_EN:
//   When defined, the stage adds the registered output 'illegal'. It flags
//   encodings the decoder does not recognise, and forces alu_ctrl to ADD
//   for those encodings.
//   When undefined, the port and all of the checking logic are absent.
// ============================================================================
module alu_decoder_stage #(
    parameter int XLEN       = 32,
    parameter int CTRL_W     = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              imm_bit10,
    input  logic              op_bit5,
    input  logic              op_bit3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              is_muldiv,
    output logic              word_op
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
    ,
    output logic              illegal
`endif
);

    // ------------------------------------------------------------------------
    // ALU control codes. They are kept 5 bits wide and widened to CTRL_W at
    // the register input.
    // ------------------------------------------------------------------------
    localparam logic [4:0] C_ADD    = 5'd0;
    localparam logic [4:0] C_SUB    = 5'd1;
    localparam logic [4:0] C_AUIPC  = 5'd2;
    localparam logic [4:0] C_LUI    = 5'd3;
    localparam logic [4:0] C_BEQ    = 5'd4;
    localparam logic [4:0] C_BNE    = 5'd5;
    localparam logic [4:0] C_BLT    = 5'd6;
    localparam logic [4:0] C_BGE    = 5'd7;
    localparam logic [4:0] C_BLTU   = 5'd8;
    localparam logic [4:0] C_BGEU   = 5'd9;
    localparam logic [4:0] C_XOR    = 5'd10;
    localparam logic [4:0] C_OR     = 5'd11;
    localparam logic [4:0] C_AND    = 5'd12;
    localparam logic [4:0] C_SLT    = 5'd13;
    localparam logic [4:0] C_SLL    = 5'd14;
    localparam logic [4:0] C_SLTU   = 5'd15;
    localparam logic [4:0] C_SRL    = 5'd16;
    localparam logic [4:0] C_SRA    = 5'd17;
    localparam logic [4:0] C_MUL    = 5'd18;
    localparam logic [4:0] C_DIV    = 5'd22;
    localparam logic [4:0] C_REMU   = 5'd25;

    // ------------------------------------------------------------------------
    // Operation classes.
    // ------------------------------------------------------------------------
    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_AUIPC  = 3'd2;
    localparam logic [2:0] OP_LUI    = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_ARITH  = 3'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic IS64 = (XLEN == 64);

    // The stall counter is wide enough to hold DIV_CYCLES. It is kept at
    // least one bit wide so the code stays legal when DIV_CYCLES is 0.
    localparam int CNT_W = (DIV_CYCLES > 0) ? $clog2(DIV_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES);

    logic [4:0]       dec_ctrl;
    logic             dec_muldiv;
    logic             dec_word;
    logic [4:0]       dec_ctrl_final;
    logic             load;
    logic             ctrl_is_div;
    logic [CNT_W-1:0] stall_cnt;

`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
    logic             dec_illegal;
`endif

    // ------------------------------------------------------------------------
    // Main decode.
    // The M-extension row is recognised only in register form with
    // funct7 = 0000001. Its eight codes are laid out contiguously, so the
    // code is MUL plus funct3.
    // ------------------------------------------------------------------------
    always_comb begin
        dec_ctrl   = C_ADD;
        dec_muldiv = 1'b0;
        case (alu_op)
            OP_ADD:   dec_ctrl = C_ADD;
            OP_SUB:   dec_ctrl = C_SUB;
            OP_AUIPC: dec_ctrl = C_AUIPC;
            OP_LUI:   dec_ctrl = C_LUI;
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  dec_ctrl = C_BEQ;
                    3'b001:  dec_ctrl = C_BNE;
                    3'b100:  dec_ctrl = C_BLT;
                    3'b101:  dec_ctrl = C_BGE;
                    3'b110:  dec_ctrl = C_BLTU;
                    3'b111:  dec_ctrl = C_BGEU;
                    default: dec_ctrl = C_ADD;
                endcase
            end
            OP_ARITH: begin
                if (op_bit5 && (funct7 == F7_MUL)) begin
                    dec_ctrl   = C_MUL + {2'b00, funct3};
                    dec_muldiv = 1'b1;
                end else begin
                    case (funct3)
                        // In the immediate form, funct7 belongs to the
                        // immediate. So SUB exists only in register form.
                        3'b000: dec_ctrl = (op_bit5 && funct7[5]) ? C_SUB : C_ADD;
                        3'b001: dec_ctrl = C_SLL;
                        3'b010: dec_ctrl = C_SLT;
                        3'b011: dec_ctrl = C_SLTU;
                        3'b100: dec_ctrl = C_XOR;
                        // The register form looks at funct7[5]; the immediate
                        // form looks at instr[30].
                        3'b101: dec_ctrl = ((op_bit5 && !funct7[5]) ||
                                            (!op_bit5 && !imm_bit10)) ? C_SRL : C_SRA;
                        3'b110: dec_ctrl = C_OR;
                        3'b111: dec_ctrl = C_AND;
                        default: dec_ctrl = C_ADD;
                    endcase
                end
            end
            default: dec_ctrl = C_ADD;
        endcase
    end

    // W-variant flag. It is meaningful only on RV64; on RV32 it is always 0.
    always_comb begin
        dec_word = IS64 & op_bit3;
    end

`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
    // ------------------------------------------------------------------------
    // Illegal-encoding detection. A flagged op still reaches execute, but with
    // an ADD control code, so downstream never sees a half-decoded operation.
    // ------------------------------------------------------------------------
    always_comb begin
        dec_illegal = 1'b0;
        case (alu_op)
            OP_BRANCH: dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OP_ARITH: begin
                if (op_bit5) begin
                    if ((funct7 != F7_BASE) && (funct7 != F7_ALT) && (funct7 != F7_MUL))
                        dec_illegal = 1'b1;
                    if ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101))
                        dec_illegal = 1'b1;
                end
            end
            OP_ADD, OP_SUB, OP_AUIPC, OP_LUI: dec_illegal = 1'b0;
            default: dec_illegal = 1'b1;
        endcase
        if (!IS64 && op_bit3)
            dec_illegal = 1'b1;
    end

    always_comb begin
        dec_ctrl_final = dec_illegal ? C_ADD : dec_ctrl;
    end
`else
    always_comb begin
        dec_ctrl_final = dec_ctrl;
    end
`endif

    // ------------------------------------------------------------------------
    // Handshake.
    // The register can take a new op in two cases: it is empty, or its
    // current op is leaving this cycle. It never takes one while the divider
    // model is busy or while a flush is in progress.
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready = (!out_valid || out_ready) && (stall_cnt == '0) && !flush;
        load     = in_valid && in_ready;
    end

    // A divide-class op is any code from DIV to REMU.
    always_comb begin
        ctrl_is_div = (alu_ctrl >= CTRL_W'(C_DIV)) && (alu_ctrl <= CTRL_W'(C_REMU));
    end

    // ------------------------------------------------------------------------
    // Control state: valid bit and divider stall counter. Flush wins over any
    // load, drain or counter reload in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (load)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (out_valid && out_ready && ctrl_is_div)
                stall_cnt <= CNT_LOAD;
            else if (stall_cnt != '0)
                stall_cnt <= stall_cnt - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Data fields. They load only on an accepted op, so they stay stable
    // while execute applies back-pressure.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_ctrl  <= '0;
            is_muldiv <= 1'b0;
            word_op   <= 1'b0;
        end else if (load) begin
            alu_ctrl  <= CTRL_W'(dec_ctrl_final);
            is_muldiv <= dec_muldiv;
            word_op   <= dec_word;
        end
    end

`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            illegal <= 1'b0;
        else if (load)
            illegal <= dec_illegal;
    end
`endif

endmodule

// File: tb/tb_alu_decoder_stage.sv
// ============================================================================
// tb_alu_decoder_stage
// Drives a 32-bit and a 64-bit instance of alu_decoder_stage. Both instances
// share the same inputs and use DIV_CYCLES=4, so their handshakes run in
// lock-step.
// ============================================================================
module tb_alu_decoder_stage;

    localparam int DIVC = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       imm_bit10;
    logic       op_bit5;
    logic       op_bit3;

    logic       in_ready, out_valid, is_muldiv, word_op;
    logic [4:0] alu_ctrl;
    logic       in_ready64, out_valid64, is_muldiv64, word_op64;
    logic [4:0] alu_ctrl64;
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
    logic       illegal, illegal64;
`endif

    int total = 0;
    int bad   = 0;

    // Device under test: 32-bit instance.
    alu_decoder_stage #(.XLEN(32), .CTRL_W(5), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
        .imm_bit10(imm_bit10), .op_bit5(op_bit5), .op_bit3(op_bit3),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .is_muldiv(is_muldiv), .word_op(word_op)
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
        , .illegal(illegal)
`endif
    );

    // Device under test: 64-bit instance.
    alu_decoder_stage #(.XLEN(64), .CTRL_W(5), .DIV_CYCLES(DIVC)) dut64 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
        .imm_bit10(imm_bit10), .op_bit5(op_bit5), .op_bit3(op_bit3),
        .out_valid(out_valid64), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl64), .is_muldiv(is_muldiv64), .word_op(word_op64)
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
        , .illegal(illegal64)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       i10;
        logic       b5;
        logic       b3;
        int         ctrl;
        bit         md;
        bit         w64;
        bit         ill32;
        bit         ill64;
    } vec_t;

    // Compares one value and reports a failure on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Advances to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder, built from lookup tables and the decode rules.
    function automatic void refDecode(input logic [2:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic i10,
                                      input logic b5, input logic b3, input int xlen,
                                      output int ctrl, output bit md,
                                      output bit wo, output bit ill);
        int branchMap[8];
        int aluMap[8];
        branchMap = '{4, 5, 0, 0, 6, 7, 8, 9};
        aluMap    = '{0, 14, 13, 15, 10, 16, 11, 12};
        ctrl = 0;
        md   = 1'b0;
        ill  = 1'b0;
        if (op <= 3) begin
            ctrl = int'(op);
        end else if (op == 4) begin
            ctrl = branchMap[f3];
            ill  = (f3 == 2) || (f3 == 3);
        end else if (op == 5) begin
            if (b5 && f7 == 7'd1) begin
                ctrl = 18 + int'(f3);
                md   = 1'b1;
            end else begin
                ctrl = aluMap[f3];
                if (f3 == 0 && b5 && f7[5]) ctrl = 1;
                if (f3 == 5 && !((b5 && !f7[5]) || (!b5 && !i10))) ctrl = 17;
            end
            if (b5 && !(f7 == 7'd0 || f7 == 7'd32 || f7 == 7'd1)) ill = 1'b1;
            if (b5 && f7 == 7'd32 && !(f3 == 0 || f3 == 5)) ill = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (xlen == 32 && b3) ill = 1'b1;
        wo = (xlen == 64) && b3;
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
        if (ill) ctrl = 0;
`endif
    endfunction

    // Offers one op and waits, within a bounded number of cycles, until it
    // is accepted.
    task automatic applyStimulus(input vec_t v);
        alu_op    = v.op;
        funct3    = v.f3;
        funct7    = v.f7;
        imm_bit10 = v.i10;
        op_bit5   = v.b5;
        op_bit3   = v.b3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 20 && !in_ready; k++) tick();
        checkOutput("vec_accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        resetn    = 1'b0;
        #3;
        resetn    = 1'b1;
        tick();
    endtask

    task automatic setFields(input logic [2:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic i10, input logic b5);
        alu_op    = op;
        funct3    = f3;
        funct7    = f7;
        imm_bit10 = i10;
        op_bit5   = b5;
        op_bit3   = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        int e32, e64, lows;
        // Reference-model state for the randomized run.
        bit mv;
        int mcnt, mctrl32, mctrl64;
        bit mmd, mwo32, mwo64, mill32, mill64;
        bit expReady, xfer, ld;
        int c32, c64;
        bit d_md, d_wo32, d_wo64, d_ill32, d_ill64;

        // Table of vectors: {op, f3, f7, i10, b5, b3, ctrl, md, w64, ill32, ill64}.
        vecs.push_back('{3'd0, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd1, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd2, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd3, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0,  4, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 3'd1, 7'h00, 1'b0, 1'b0, 1'b0,  5, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 3'd4, 7'h00, 1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 3'd5, 7'h00, 1'b0, 1'b0, 1'b0,  7, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 3'd6, 7'h00, 1'b0, 1'b0, 1'b0,  8, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 3'd7, 7'h00, 1'b0, 1'b0, 1'b0,  9, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd4, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3'd5, 3'd0, 7'h20, 1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd0, 7'h20, 1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd5, 7'h20, 1'b1, 1'b0, 1'b0, 17, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd5, 7'h00, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd5, 7'h00, 1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd5, 7'h20, 1'b0, 1'b1, 1'b0, 17, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd1, 7'h00, 1'b0, 1'b1, 1'b0, 14, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd2, 7'h00, 1'b0, 1'b1, 1'b0, 13, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd3, 7'h00, 1'b0, 1'b1, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd4, 7'h00, 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd6, 7'h00, 1'b0, 1'b1, 1'b0, 11, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd7, 7'h00, 1'b0, 1'b1, 1'b0, 12, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd0, 7'h01, 1'b0, 1'b1, 1'b0, 18, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd3, 7'h01, 1'b0, 1'b1, 1'b0, 21, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd4, 7'h01, 1'b0, 1'b1, 1'b0, 22, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd7, 7'h01, 1'b0, 1'b1, 1'b0, 25, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{3'd5, 3'd0, 7'h00, 1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{3'd6, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3'd7, 3'd3, 7'h00, 1'b0, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3'd5, 3'd0, 7'h40, 1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{3'd5, 3'd4, 7'h20, 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b1, 1'b1});

        // Reset state, checked while reset is held.
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        setFields(3'd0, 3'd0, 7'h00, 1'b0, 1'b0);
        #2;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_alu_ctrl", alu_ctrl, 0);
        checkOutput("reset_is_muldiv", is_muldiv, 0);
        checkOutput("reset_word_op64", word_op64, 0);
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
        checkOutput("reset_illegal", illegal, 0);
`endif
        #2;
        resetn = 1'b1;
        tick();
        checkOutput("after_reset_in_ready", in_ready, 1);

        // Table-driven decode checks.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            e32 = vecs[i].ctrl;
            e64 = vecs[i].ctrl;
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
            if (vecs[i].ill32) e32 = 0;
            if (vecs[i].ill64) e64 = 0;
            checkOutput($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill32);
            checkOutput($sformatf("vec%0d_illegal64", i), illegal64, vecs[i].ill64);
`endif
            checkOutput($sformatf("vec%0d_out_valid", i), out_valid, 1);
            checkOutput($sformatf("vec%0d_alu_ctrl", i), alu_ctrl, e32);
            checkOutput($sformatf("vec%0d_alu_ctrl64", i), alu_ctrl64, e64);
            checkOutput($sformatf("vec%0d_is_muldiv", i), is_muldiv, vecs[i].md);
            checkOutput($sformatf("vec%0d_word_op", i), word_op, 0);
            checkOutput($sformatf("vec%0d_word_op64", i), word_op64, vecs[i].w64);
        end

        // Asynchronous reset while a result is held.
        doReset();
        setFields(3'd1, 3'd0, 7'h00, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("midreset_loaded", out_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_alu_ctrl", alu_ctrl, 0);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("midreset_in_ready", in_ready, 1);

        // Back-pressure, then back-to-back transfer.
        doReset();
        out_ready = 1'b0;
        setFields(3'd1, 3'd0, 7'h00, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        setFields(3'd5, 3'd4, 7'h00, 1'b0, 1'b1);
        #1;
        checkOutput("bp_in_ready_low", in_ready, 0);
        tick();
        checkOutput("bp_held_valid", out_valid, 1);
        checkOutput("bp_held_ctrl", alu_ctrl, 1);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_high", in_ready, 1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_second_valid", out_valid, 1);
        checkOutput("bp_second_ctrl", alu_ctrl, 10);
        tick();
        checkOutput("bp_drained", out_valid, 0);

        // Divider stall: in_ready stays low for exactly DIVC cycles.
        doReset();
        setFields(3'd5, 3'd4, 7'h01, 1'b0, 1'b1);
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        checkOutput("div_ctrl", alu_ctrl, 22);
        checkOutput("div_muldiv", is_muldiv, 1);
        tick();
        lows = 0;
        for (int k = 0; k < 12 && !in_ready; k++) begin
            lows++;
            tick();
        end
        checkOutput("div_stall_len", lows, DIVC);
        checkOutput("div_stall_end_ready", in_ready, 1);

        // Flush while a result is held and the stall counter is 3.
        doReset();
        setFields(3'd5, 3'd4, 7'h01, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        setFields(3'd0, 3'd0, 7'h00, 1'b0, 1'b0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        checkOutput("flush_pre_valid", out_valid, 1);
        checkOutput("flush_pre_ready", in_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_in_ready", in_ready, 1);

        // Randomized run against the reference model.
        doReset();
        mv = 0; mcnt = 0; mctrl32 = 0; mctrl64 = 0; mmd = 0;
        mwo32 = 0; mwo64 = 0; mill32 = 0; mill64 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checkOutput("rnd_out_valid", out_valid, mv);
            checkOutput("rnd_out_valid64", out_valid64, mv);
            if (mv) begin
                checkOutput("rnd_alu_ctrl", alu_ctrl, mctrl32);
                checkOutput("rnd_alu_ctrl64", alu_ctrl64, mctrl64);
                checkOutput("rnd_is_muldiv", is_muldiv, mmd);
                checkOutput("rnd_word_op", word_op, mwo32);
                checkOutput("rnd_word_op64", word_op64, mwo64);
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
                checkOutput("rnd_illegal", illegal, mill32);
                checkOutput("rnd_illegal64", illegal64, mill64);
`endif
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            alu_op    = 3'($urandom_range(0, 7));
            funct3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       funct7 = 7'h00;
                1:       funct7 = 7'h20;
                2:       funct7 = 7'h01;
                default: funct7 = 7'($urandom_range(0, 127));
            endcase
            imm_bit10 = 1'($urandom_range(0, 1));
            op_bit5   = 1'($urandom_range(0, 1));
`ifdef ALU_DECODER_ILLEGAL_CHECK_EN
            op_bit3   = 1'b0;
`else
            op_bit3   = 1'($urandom_range(0, 1));
`endif
            #1;
            expReady = (!mv || out_ready) && (mcnt == 0) && !flush;
            checkOutput("rnd_in_ready", in_ready, expReady);
            checkOutput("rnd_in_ready64", in_ready64, expReady);
            if (flush) begin
                mv = 0;
                mcnt = 0;
            end else begin
                xfer = mv && out_ready;
                ld   = in_valid && expReady;
                if (xfer && mctrl32 >= 22 && mctrl32 <= 25) mcnt = DIVC;
                else if (mcnt > 0) mcnt--;
                if (ld) begin
                    refDecode(alu_op, funct3, funct7, imm_bit10, op_bit5, op_bit3, 32,
                              c32, d_md, d_wo32, d_ill32);
                    refDecode(alu_op, funct3, funct7, imm_bit10, op_bit5, op_bit3, 64,
                              c64, d_md, d_wo64, d_ill64);
                    mv = 1; mctrl32 = c32; mctrl64 = c64; mmd = d_md;
                    mwo32 = d_wo32; mwo64 = d_wo64; mill32 = d_ill32; mill64 = d_ill64;
                end else if (xfer) begin
                    mv = 0;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
